cover_toggle_collector: RTL and testbench
=========================================

# cover_toggle_collector

Parametrised coverage-point collector that replaces per-bit, per-cycle DPI reporting for a group of toggle cover points. It captures hits on a WIDTH-bit vector into a pending bitmap and serialises them as one indexed event per cycle over a valid/ready channel. It also keeps a sticky covered bitmap, a covered-point count, and a saturating drop counter. It sits between instrumented design signals and the single coverage sink, whether that sink is a DPI bridge or a formal monitor.

## Interface
- WIDTH, 36: number of cover points in this group (1..1024).
- COVER_INDEX, 0: global index of point 0; point i reports as COVER_INDEX + i.
- COVER_TOTAL, 9715: total points in the design; used only by the bound assertion COVER_INDEX + WIDTH <= COVER_TOTAL.
- FIRST_ONLY, 1: 1 = a point is reported only on its first hit since reset/clear; 0 = every hit is reported, with coalescing.
- EDGE_DETECT, 0: 0 = `valid[i]` is a hit strobe; 1 = a hit is any change of `valid[i]` versus its previous sampled value.
- CNT_W, $clog2(WIDTH+1): width of `covered_count`.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- valid  in  WIDTH  hit strobes, or raw signals when EDGE_DETECT=1.
- cover_clear  in  1  synchronous clear of the pending and covered bitmaps, count, and drops. Does not affect the output register.
- ev_valid  out  1  event available.
- ev_ready  in  1  sink accepts event when ev_valid && ev_ready.
- ev_index  out  64  global cover index of the presented event.
- covered_count  out  CNT_W  number of points with the covered bit set.
- all_covered  out  1  high when covered_count == WIDTH.
- drop_count  out  16  saturating count of coalesced hits (FIRST_ONLY=0 only).

## Operation
- Hit vector h:
  - EDGE_DETECT=0: h = valid.
  - EDGE_DETECT=1: h = valid ^ prev. prev is registered every cycle. The first cycle after reset deassertion produces no hits; prev loads only.
- Effective hits:
  - FIRST_ONLY=1: e = h & ~covered.
  - FIRST_ONLY=0: e = h.
- Each edge: covered |= h; pending |= e; covered_count is updated from the new covered bitmap, registered.
- Drops (FIRST_ONLY=0): for each bit with e[i] && pending[i] already set, drop_count increments by popcount of such bits, saturating at 0xFFFF. The pending bit stays set, and only one event is later emitted.
- Output register (ev_valid, ev_index) loads when !ev_valid || ev_ready:
  - The lowest-index set bit of pending is chosen.
  - ev_index = COVER_INDEX + i, as 64-bit unsigned.
  - That bit is cleared from pending in the same edge.
  - If no bit is pending, ev_valid goes 0.
- Simultaneous events on the same bit i in the same cycle:
  - Selection of bit i plus a new hit on bit i: the bit is cleared by selection, then set again by the new hit when FIRST_ONLY=0, with no drop counted. When FIRST_ONLY=1 the new hit is masked by covered.
- cover_clear:
  - pending, covered, covered_count, and drop_count go 0 at the edge; hits in that cycle are discarded.
  - prev still loads.
  - An event already in the output register stays presented until accepted.
- Parameter check: a simulation-only assertion fires if COVER_INDEX + WIDTH > COVER_TOTAL.

## Timing
- Reset values: ev_valid=0, ev_index=0, covered_count=0, all_covered=0, drop_count=0, pending=0, covered=0, prev=0.
- Reset mid-operation drops any presented or pending events without handshake.
- Latency: a hit sampled at edge E0 sets pending. The output register loads at E1, so ev_valid is high after E1: 2 cycles when the channel is idle.
- Throughput: one event per cycle while ev_ready=1. A full burst of WIDTH simultaneous hits drains in WIDTH cycles, in ascending index order.
- Stability: while ev_valid && !ev_ready, ev_valid and ev_index are held unchanged. Lower-index hits arriving meanwhile wait in pending.
- covered_count and all_covered reflect hits sampled at edge E0 after E0, with 1-cycle latency.
- Outputs are registered; there is no combinational path from `valid` or `ev_ready` to any output.

## Test plan
- **First-hit ordering.** WIDTH=36, COVER_INDEX=100, FIRST_ONLY=1, ev_ready=1. Pulse valid[5] and valid[2] in one cycle. Required: ev_index 102 then 105 on consecutive cycles, starting 2 cycles after the pulse; covered_count=2. Re-pulsing bit 5 produces no event.
- **Backpressure stability.** Hold ev_ready=0, pulse bits 10, 3, then 0 on successive cycles. Required: ev_index stays 110 while stalled. Raising ev_ready yields 110, 100, 103 in that order.
- **Coalescing.** FIRST_ONLY=0, ev_ready=0, pulse bit 7 three times. Required: drop_count=2. After release, exactly one event with index 107.
- **Edge detect.** EDGE_DETECT=1, valid held at 36'hF from reset. Required: no events. Toggle bit 1 to 0 then back to 1. Required: two events with index 101 (FIRST_ONLY=0).
- **Full coverage and clear.** Pulse all 36 bits with ev_ready=1. Required: events 100..135 in 36 consecutive cycles, all_covered=1. After cover_clear, covered_count=0 and bit 0 is reportable again.
- **Async reset.** Assert reset mid-burst, asynchronous to clock. Required: ev_valid=0 and all counters 0 immediately. No stale events after release.

Source files
------------

// File: rtl/cover_toggle_collector.sv
// Toggle cover-point collector: captures hits into a pending bitmap and serialises them
// as one indexed event per cycle, with sticky covered bitmap, covered count and drop counter.
module cover_toggle_collector #(
  parameter int unsigned     WIDTH       = 36,
  parameter longint unsigned COVER_INDEX = 0,
  parameter longint unsigned COVER_TOTAL = 9715,
  parameter bit              FIRST_ONLY  = 1'b1,
  parameter bit              EDGE_DETECT = 1'b0,
  parameter int unsigned     CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] valid,
  input  logic             cover_clear,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [63:0]      ev_index,
  output logic [CNT_W-1:0] covered_count,
  output logic             all_covered,
  output logic [15:0]      drop_count
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned POP_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] prev_reg;
  logic             primed_reg;
  logic [WIDTH-1:0] pending_reg;
  logic [WIDTH-1:0] covered_reg;
  logic [CNT_W-1:0] covered_count_reg;
  logic             all_covered_reg;
  logic [15:0]      drop_count_reg;
  logic             ev_valid_reg;
  logic [63:0]      ev_index_reg;

  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] eff;
  logic [WIDTH-1:0] drop_vec;
  logic [WIDTH-1:0] sel_onehot;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             load;
  logic             take;
  logic [WIDTH-1:0] pending_kept;
  logic [WIDTH-1:0] pending_next;
  logic [WIDTH-1:0] covered_next;
  logic [POP_W-1:0] cov_pop;
  logic [POP_W-1:0] drop_pop;
  logic [16:0]      drop_sum;
  logic [15:0]      drop_count_next;

  function automatic logic [POP_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [POP_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      acc = acc + POP_W'(v[i]);
    end
    return acc;
  endfunction

  // Edge mode stays silent until prev has been loaded once after reset.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign hit[gi]      = EDGE_DETECT ? (primed_reg & (valid[gi] ^ prev_reg[gi])) : valid[gi];
      assign eff[gi]      = FIRST_ONLY ? (hit[gi] & ~covered_reg[gi]) : hit[gi];
      assign drop_vec[gi] = !FIRST_ONLY && eff[gi] && pending_kept[gi];
    end
  endgenerate

  // Lowest set bit of pending wins; isolate it with the two's-complement trick.
  assign sel_onehot = pending_reg & (~pending_reg + WIDTH'(1));
  assign sel_found  = |pending_reg;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel_onehot[i]) begin
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign load = !ev_valid_reg || ev_ready;
  assign take = load && sel_found && !cover_clear;

  // Selection clears its bit before new hits are merged, so a re-hit on the selected bit is not a drop.
  assign pending_kept = pending_reg & ~(take ? sel_onehot : '0);
  assign pending_next = cover_clear ? '0 : (pending_kept | eff);
  assign covered_next = cover_clear ? '0 : (covered_reg | hit);

  assign cov_pop  = popcount(covered_next);
  assign drop_pop = popcount(drop_vec);
  assign drop_sum = {1'b0, drop_count_reg} + 17'(drop_pop);
  assign drop_count_next = cover_clear ? 16'd0 : (drop_sum[16] ? 16'hFFFF : drop_sum[15:0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_reg          <= '0;
      primed_reg        <= 1'b0;
      pending_reg       <= '0;
      covered_reg       <= '0;
      covered_count_reg <= '0;
      all_covered_reg   <= 1'b0;
      drop_count_reg    <= '0;
      ev_valid_reg      <= 1'b0;
      ev_index_reg      <= '0;
    end else begin
      prev_reg          <= valid;
      primed_reg        <= 1'b1;
      pending_reg       <= pending_next;
      covered_reg       <= covered_next;
      covered_count_reg <= CNT_W'(cov_pop);
      all_covered_reg   <= (cov_pop == POP_W'(WIDTH));
      drop_count_reg    <= drop_count_next;
      if (load) begin
        ev_valid_reg <= take;
        if (take) begin
          ev_index_reg <= COVER_INDEX + 64'(sel_idx);
        end
      end
    end
  end

  assign ev_valid      = ev_valid_reg;
  assign ev_index      = ev_index_reg;
  assign covered_count = covered_count_reg;
  assign all_covered   = all_covered_reg;
  assign drop_count    = drop_count_reg;

  // Global index range of this group must fit inside the design's cover point total.
  assert property (@(posedge clock) disable iff (reset) (COVER_INDEX + WIDTH <= COVER_TOTAL))
    else $error("cover_toggle_collector: COVER_INDEX + WIDTH exceeds COVER_TOTAL");

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Self-checking bench for cover_toggle_collector: directed scenarios on three parameterisations
// plus a randomized run compared against a bitmap-level reference model.
module tb_cover_toggle_collector;

  localparam int W = 36;
  localparam longint BASE = 100;

  logic clock = 1'b0;
  logic reset;
  logic cover_clear;

  logic [W-1:0] valid_f, valid_c, valid_e;
  logic         ready_f, ready_c, ready_e;
  logic         evv_f, evv_c, evv_e;
  logic [63:0]  evi_f, evi_c, evi_e;
  logic [5:0]   cnt_f, cnt_c, cnt_e;
  logic         allc_f, allc_c, allc_e;
  logic [15:0]  drop_f, drop_c, drop_e;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cover_toggle_collector #(.WIDTH(W), .COVER_INDEX(BASE), .COVER_TOTAL(9715),
                           .FIRST_ONLY(1'b1), .EDGE_DETECT(1'b0)) dut_f (
    .clock(clock), .reset(reset), .valid(valid_f), .cover_clear(cover_clear),
    .ev_valid(evv_f), .ev_ready(ready_f), .ev_index(evi_f),
    .covered_count(cnt_f), .all_covered(allc_f), .drop_count(drop_f));

  cover_toggle_collector #(.WIDTH(W), .COVER_INDEX(BASE), .COVER_TOTAL(9715),
                           .FIRST_ONLY(1'b0), .EDGE_DETECT(1'b0)) dut_c (
    .clock(clock), .reset(reset), .valid(valid_c), .cover_clear(cover_clear),
    .ev_valid(evv_c), .ev_ready(ready_c), .ev_index(evi_c),
    .covered_count(cnt_c), .all_covered(allc_c), .drop_count(drop_c));

  cover_toggle_collector #(.WIDTH(W), .COVER_INDEX(BASE), .COVER_TOTAL(9715),
                           .FIRST_ONLY(1'b0), .EDGE_DETECT(1'b1)) dut_e (
    .clock(clock), .reset(reset), .valid(valid_e), .cover_clear(cover_clear),
    .ev_valid(evv_e), .ev_ready(ready_e), .ev_index(evi_e),
    .covered_count(cnt_e), .all_covered(allc_e), .drop_count(drop_e));

  function automatic logic [W-1:0] bit_of(input int n);
    logic [W-1:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    checks++;
    if (evv_f !== 1'b0 || evi_f !== 64'd0 || cnt_f !== 6'd0 || allc_f !== 1'b0 || drop_f !== 16'd0) begin
      errors++;
      $display("FAIL reset_f got v=%0b i=%0d c=%0d a=%0b d=%0d want all 0", evv_f, evi_f, cnt_f, allc_f, drop_f);
    end
    checks++;
    if (evv_c !== 1'b0 || cnt_c !== 6'd0 || drop_c !== 16'd0 || evv_e !== 1'b0) begin
      errors++;
      $display("FAIL reset_ce got vc=%0b cc=%0d dc=%0d ve=%0b want all 0", evv_c, cnt_c, drop_c, evv_e);
    end
    // valid_e held at 'hF through reset must not look like a toggle.
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (evv_e !== 1'b0 || cnt_e !== 6'd0) begin
        errors++;
        $display("FAIL edge_prime got v=%0b cnt=%0d want v=0 cnt=0", evv_e, cnt_e);
      end
    end
    $display("reset: state checked after release");
  endtask

  task automatic test_first_hit();
    ready_f = 1'b1;
    valid_f = bit_of(5) | bit_of(2);
    @(negedge clock);
    valid_f = '0;
    checks++;
    if (evv_f !== 1'b0 || cnt_f !== 6'd2) begin
      errors++;
      $display("FAIL first_hit_lat got v=%0b cnt=%0d want v=0 cnt=2", evv_f, cnt_f);
    end
    @(negedge clock);
    checks++;
    if (evv_f !== 1'b1 || evi_f !== 64'd102) begin
      errors++;
      $display("FAIL first_hit_ev0 got v=%0b idx=%0d want v=1 idx=102", evv_f, evi_f);
    end
    $display("first_hit: event idx=%0d", evi_f);
    @(negedge clock);
    checks++;
    if (evv_f !== 1'b1 || evi_f !== 64'd105) begin
      errors++;
      $display("FAIL first_hit_ev1 got v=%0b idx=%0d want v=1 idx=105", evv_f, evi_f);
    end
    $display("first_hit: event idx=%0d", evi_f);
    @(negedge clock);
    checks++;
    if (evv_f !== 1'b0) begin
      errors++;
      $display("FAIL first_hit_drain got v=%0b want 0", evv_f);
    end
    valid_f = bit_of(5);
    @(negedge clock);
    valid_f = '0;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (evv_f !== 1'b0 || cnt_f !== 6'd2) begin
        errors++;
        $display("FAIL first_hit_rehit got v=%0b cnt=%0d want v=0 cnt=2", evv_f, cnt_f);
      end
    end
  endtask

  task automatic test_backpressure();
    longint exp_bp[3];
    exp_bp = '{110, 100, 103};
    ready_f = 1'b0;
    valid_f = bit_of(10);
    @(negedge clock);
    valid_f = bit_of(3);
    @(negedge clock);
    valid_f = bit_of(0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (evv_f !== 1'b1 || evi_f !== 64'd110) begin
        errors++;
        $display("FAIL bp_stall%0d got v=%0b idx=%0d want v=1 idx=110", k, evv_f, evi_f);
      end
      @(negedge clock);
      valid_f = '0;
    end
    ready_f = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (evv_f !== 1'b1 || evi_f !== 64'(exp_bp[k])) begin
        errors++;
        $display("FAIL bp_order%0d got v=%0b idx=%0d want v=1 idx=%0d", k, evv_f, evi_f, exp_bp[k]);
      end
      $display("backpressure: accept idx=%0d", evi_f);
      @(negedge clock);
    end
    checks++;
    if (evv_f !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got v=%0b want 0", evv_f);
    end
  endtask

  task automatic test_coalesce();
    int n;
    ready_c = 1'b0;
    valid_c = bit_of(0);
    @(negedge clock);
    valid_c = '0;
    @(negedge clock);
    checks++;
    if (evv_c !== 1'b1 || evi_c !== 64'd100) begin
      errors++;
      $display("FAIL coal_hold got v=%0b idx=%0d want v=1 idx=100", evv_c, evi_c);
    end
    repeat (3) begin
      valid_c = bit_of(7);
      @(negedge clock);
    end
    valid_c = '0;
    @(negedge clock);
    checks++;
    if (drop_c !== 16'd2) begin
      errors++;
      $display("FAIL coal_drops got %0d want 2", drop_c);
    end
    ready_c = 1'b1;
    @(negedge clock);
    checks++;
    if (evv_c !== 1'b1 || evi_c !== 64'd107) begin
      errors++;
      $display("FAIL coal_ev got v=%0b idx=%0d want v=1 idx=107", evv_c, evi_c);
    end
    n = 0;
    repeat (3) begin
      @(negedge clock);
      if (evv_c === 1'b1) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL coal_single got %0d extra events want 0", n);
    end
    $display("coalesce: drops=%0d single event idx=107", drop_c);
  endtask

  task automatic test_edge();
    int n, n101;
    ready_e = 1'b1;
    valid_e[1] = 1'b0;
    @(negedge clock);
    valid_e[1] = 1'b1;
    @(negedge clock);
    n = 0;
    n101 = 0;
    repeat (5) begin
      if (evv_e === 1'b1) begin
        n++;
        if (evi_e === 64'd101) n101++;
        $display("edge: accept idx=%0d", evi_e);
      end
      @(negedge clock);
    end
    checks++;
    if (n != 2 || n101 != 2) begin
      errors++;
      $display("FAIL edge_events got total=%0d idx101=%0d want 2 and 2", n, n101);
    end
    checks++;
    if (drop_e !== 16'd0 || cnt_e !== 6'd1) begin
      errors++;
      $display("FAIL edge_counts got drops=%0d cnt=%0d want 0 and 1", drop_e, cnt_e);
    end
  endtask

  task automatic test_full_clear();
    int bad;
    cover_clear = 1'b1;
    @(negedge clock);
    cover_clear = 1'b0;
    checks++;
    if (cnt_f !== 6'd0) begin
      errors++;
      $display("FAIL full_preclear got cnt=%0d want 0", cnt_f);
    end
    ready_f = 1'b1;
    valid_f = '1;
    @(negedge clock);
    valid_f = '0;
    checks++;
    if (cnt_f !== 6'd36 || allc_f !== 1'b1) begin
      errors++;
      $display("FAIL full_cov got cnt=%0d all=%0b want 36 and 1", cnt_f, allc_f);
    end
    bad = 0;
    for (int k = 0; k < W; k++) begin
      @(negedge clock);
      checks++;
      if (evv_f !== 1'b1 || evi_f !== 64'(BASE + k)) begin
        errors++;
        bad++;
        $display("FAIL full_ev%0d got v=%0b idx=%0d want v=1 idx=%0d", k, evv_f, evi_f, BASE + k);
      end
    end
    $display("full: 36-event burst drained, mismatching slots=%0d", bad);
    @(negedge clock);
    checks++;
    if (evv_f !== 1'b0) begin
      errors++;
      $display("FAIL full_drain got v=%0b want 0", evv_f);
    end
    cover_clear = 1'b1;
    @(negedge clock);
    cover_clear = 1'b0;
    checks++;
    if (cnt_f !== 6'd0 || allc_f !== 1'b0) begin
      errors++;
      $display("FAIL clear_cnt got cnt=%0d all=%0b want 0 and 0", cnt_f, allc_f);
    end
    valid_f = bit_of(0);
    @(negedge clock);
    valid_f = '0;
    @(negedge clock);
    checks++;
    if (evv_f !== 1'b1 || evi_f !== 64'd100) begin
      errors++;
      $display("FAIL clear_rehit got v=%0b idx=%0d want v=1 idx=100", evv_f, evi_f);
    end
    $display("clear: bit 0 reported again idx=%0d", evi_f);
  endtask

  task automatic test_async_reset();
    ready_c = 1'b1;
    valid_c = '1;
    @(negedge clock);
    @(negedge clock);
    valid_c = '0;
    checks++;
    if (drop_c !== 16'd35) begin
      errors++;
      $display("FAIL burst_drops got %0d want 35", drop_c);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (evv_c !== 1'b1) begin
      errors++;
      $display("FAIL burst_mid got v=%0b want 1", evv_c);
    end
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    checks++;
    if (evv_c !== 1'b0 || cnt_c !== 6'd0 || drop_c !== 16'd0 || allc_c !== 1'b0 || cnt_f !== 6'd0 || evi_c !== 64'd0) begin
      errors++;
      $display("FAIL async_reset got v=%0b cnt=%0d drop=%0d idx=%0d want all 0", evv_c, cnt_c, drop_c, evi_c);
    end
    @(posedge clock);
    #2 reset = 1'b0;
    repeat (5) begin
      @(negedge clock);
      checks++;
      if (evv_c !== 1'b0 || evv_f !== 1'b0 || evv_e !== 1'b0) begin
        errors++;
        $display("FAIL post_reset got vc=%0b vf=%0b ve=%0b want 0", evv_c, evv_f, evv_e);
      end
    end
    $display("async_reset: outputs cleared mid-burst");
  endtask

  task automatic test_random();
    bit     m_pend[W];
    bit     m_cov[W];
    int     m_drops;
    bit     m_v;
    longint m_idx;
    int     j, ncov;
    bit     ld;
    for (int i = 0; i < W; i++) begin
      m_pend[i] = 1'b0;
      m_cov[i]  = 1'b0;
    end
    m_drops = 0;
    m_v = 1'b0;
    m_idx = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 2) == 0)
        valid_c = W'({$urandom(), $urandom()} & {$urandom(), $urandom()});
      else
        valid_c = '0;
      ready_c = 1'($urandom_range(0, 1));
      cover_clear = ($urandom_range(0, 49) == 0);
      if (evv_c === 1'b1 && ready_c) $display("random: cycle %0d accept idx=%0d", cyc, evi_c);
      ld = !m_v || ready_c;
      j = -1;
      for (int i = 0; i < W; i++) if (m_pend[i] && j < 0) j = i;
      if (ld) begin
        if (cover_clear || j < 0) m_v = 1'b0;
        else begin
          m_v = 1'b1;
          m_idx = BASE + j;
          m_pend[j] = 1'b0;
        end
      end
      for (int i = 0; i < W; i++) begin
        if (cover_clear) begin
          m_pend[i] = 1'b0;
          m_cov[i]  = 1'b0;
        end else if (valid_c[i]) begin
          if (m_pend[i] && m_drops < 65535) m_drops++;
          m_pend[i] = 1'b1;
          m_cov[i]  = 1'b1;
        end
      end
      if (cover_clear) m_drops = 0;
      ncov = 0;
      for (int i = 0; i < W; i++) ncov += int'(m_cov[i]);
      @(negedge clock);
      checks++;
      if (evv_c !== m_v || (m_v && evi_c !== 64'(m_idx))) begin
        errors++;
        $display("FAIL rand_ev cyc%0d got v=%0b idx=%0d want v=%0b idx=%0d", cyc, evv_c, evi_c, m_v, m_idx);
      end
      checks++;
      if (cnt_c !== 6'(ncov) || allc_c !== (ncov == W) || drop_c !== 16'(m_drops)) begin
        errors++;
        $display("FAIL rand_cnt cyc%0d got cnt=%0d all=%0b drop=%0d want cnt=%0d all=%0b drop=%0d",
                 cyc, cnt_c, allc_c, drop_c, ncov, (ncov == W), m_drops);
      end
    end
    cover_clear = 1'b0;
    valid_c = '0;
  endtask

  initial begin
    reset = 1'b1;
    cover_clear = 1'b0;
    valid_f = '0;
    valid_c = '0;
    valid_e = 36'hF;
    ready_f = 1'b0;
    ready_c = 1'b0;
    ready_e = 1'b0;
    test_reset();
    test_first_hit();
    test_backpressure();
    test_coalesce();
    test_edge();
    test_full_clear();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
